pw_capture_sequencer: RTL and testbench

- Sequences one capture: arm request, trigger-clock lock wait, armed wait for pattern match, byte-counted capture, done.
- Sits between the register block and the FE capture / pattern matcher in the fe_clk domain. Drives their arm and capturing qualifiers and returns status and byte count for register readback.

---
 rtl/pw_capture_sequencer_if.sv | 38 +++
 rtl/pw_capture_sequencer.sv | 155 +++++++++++++++
 tb/tb_pw_capture_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pw_capture_sequencer_if.sv
`default_nettype none
// pw_capture_sequencer_if: register-side / FE-side signal bundle for pw_capture_sequencer.
// The master modport drives the request side; the slave modport is the sequencer.
interface pw_capture_sequencer_if #(
    parameter int pCAPTURE_LEN_WIDTH = 16,
    parameter int pTIMEOUT_WIDTH     = 24
);
    logic                          I_arm_req;
    logic                          I_disarm;
    logic                          I_clk_locked;
    logic [pCAPTURE_LEN_WIDTH-1:0] I_capture_len;
    logic                          I_match;
    logic                          I_data_wr;
    logic                          I_fifo_full;
    logic [pTIMEOUT_WIDTH-1:0]     I_timeout;
    logic                          O_arm;
    logic                          O_capturing;
    logic                          O_done;
    logic [2:0]                    O_state;
    logic                          O_overflow;
    logic [pCAPTURE_LEN_WIDTH-1:0] O_byte_count;
    logic                          O_timed_out;

    modport master (
        output I_arm_req, I_disarm, I_clk_locked, I_capture_len,
               I_match, I_data_wr, I_fifo_full, I_timeout,
        input  O_arm, O_capturing, O_done, O_state,
               O_overflow, O_byte_count, O_timed_out
    );

    modport slave (
        input  I_arm_req, I_disarm, I_clk_locked, I_capture_len,
               I_match, I_data_wr, I_fifo_full, I_timeout,
        output O_arm, O_capturing, O_done, O_state,
               O_overflow, O_byte_count, O_timed_out
    );
endinterface
`default_nettype wire

// File: rtl/pw_capture_sequencer.sv
`default_nettype none
// pw_capture_sequencer: arm -> lock wait -> armed -> byte-counted capture -> done, in the fe_clk domain.
// Define PW_ARM_TIMEOUT_EN to add the armed-state timeout (O_timed_out); otherwise ARMED waits forever.
module pw_capture_sequencer #(
    parameter int pCAPTURE_LEN_WIDTH = 16,
    parameter int pTIMEOUT_WIDTH     = 24
) (
    input  logic                  fe_clk,
    input  logic                  reset_n,
    pw_capture_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_ARMED     = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [pCAPTURE_LEN_WIDTH-1:0] LEN_ONE = {{(pCAPTURE_LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                        state;
    state_t                        state_next;
    logic                          arm_req_q;
    logic                          arm_edge;
    logic [pCAPTURE_LEN_WIDTH-1:0] len_q;
    logic [pCAPTURE_LEN_WIDTH-1:0] count_q;
    logic [pCAPTURE_LEN_WIDTH-1:0] count_inc;
    logic                          arm_q;
    logic                          capturing_q;
    logic                          done_q;
    logic                          overflow_q;
    logic                          timed_out;
    logic                          tmo_hit;

    assign arm_edge  = bus.I_arm_req & ~arm_req_q;
    assign count_inc = (count_q == '1) ? count_q : count_q + LEN_ONE;

`ifdef PW_ARM_TIMEOUT_EN
    localparam logic [pTIMEOUT_WIDTH-1:0] TMO_ONE = {{(pTIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    logic [pTIMEOUT_WIDTH-1:0] tmo_q;
    logic [pTIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                      timed_out_q;

    // Counter holds the number of ARMED cycles already completed, so the hit fires on the Nth.
    assign tmo_hit   = (tmo_q != '0) && ((tmo_cnt + TMO_ONE) == tmo_q);
    assign timed_out = timed_out_q;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q       <= '0;
            tmo_cnt     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && arm_edge) begin
                tmo_q       <= bus.I_timeout;
                timed_out_q <= 1'b0;
            end else if (state == ST_ARMED && state_next == ST_DONE) begin
                timed_out_q <= 1'b1;
            end
            if (state == ST_ARMED && state_next == ST_ARMED)
                tmo_cnt <= tmo_cnt + TMO_ONE;
            else
                tmo_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^bus.I_timeout;
    assign tmo_hit        = 1'b0;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (arm_edge)
                    state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (bus.I_disarm)
                    state_next = ST_IDLE;
                else if (bus.I_clk_locked)
                    state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.I_disarm)
                    state_next = ST_IDLE;
                else if (!bus.I_clk_locked)
                    state_next = ST_WAIT_LOCK;
                else if (bus.I_match)
                    state_next = ST_CAPTURE;
                else if (tmo_hit)
                    state_next = ST_DONE;
            end
            ST_CAPTURE: begin
                // FIFO full is checked first so a full write on the last byte reports overflow.
                if (bus.I_disarm)
                    state_next = ST_IDLE;
                else if (bus.I_data_wr && bus.I_fifo_full)
                    state_next = ST_DONE;
                else if (bus.I_data_wr && len_q != '0 && count_inc == len_q)
                    state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_req_q   <= 1'b0;
            len_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            arm_q       <= 1'b0;
            capturing_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            arm_req_q <= bus.I_arm_req;
            if (state == ST_IDLE && arm_edge) begin
                len_q      <= bus.I_capture_len;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (state == ST_CAPTURE && !bus.I_disarm && bus.I_data_wr) begin
                if (bus.I_fifo_full)
                    overflow_q <= 1'b1;
                else
                    count_q <= count_inc;
            end
            // Qualifiers are registered from the next state so they line up with O_state.
            arm_q       <= (state_next == ST_ARMED) || (state_next == ST_CAPTURE);
            capturing_q <= (state_next == ST_CAPTURE);
            done_q      <= (state_next == ST_DONE);
        end
    end

    assign bus.O_state      = state;
    assign bus.O_arm        = arm_q;
    assign bus.O_capturing  = capturing_q;
    assign bus.O_done       = done_q;
    assign bus.O_overflow   = overflow_q;
    assign bus.O_byte_count = count_q;
    assign bus.O_timed_out  = timed_out;
endmodule
`default_nettype wire

// File: tb/tb_pw_capture_sequencer.sv
`default_nettype none
// tb_pw_capture_sequencer: directed self-checking bench for pw_capture_sequencer.
// Covers normal capture, overflow, lock loss, disarm, async reset, saturation and (with PW_ARM_TIMEOUT_EN) timeout.
module tb_pw_capture_sequencer;
    logic fe_clk;
    logic reset_n;
    int   checks;
    int   errors;

    pw_capture_sequencer_if #(.pCAPTURE_LEN_WIDTH(16), .pTIMEOUT_WIDTH(24)) bus ();

    pw_capture_sequencer #(.pCAPTURE_LEN_WIDTH(16), .pTIMEOUT_WIDTH(24)) dut (
        .fe_clk  (fe_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial fe_clk = 1'b0;
    always #5 fe_clk = ~fe_clk;

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fresh arm edge with the given length/timeout, walked through WAIT_LOCK into ARMED.
    task automatic arm_to_armed(input logic [15:0] len, input logic [23:0] tmo);
        bus.I_arm_req = 1'b0;
        tick();
        bus.I_capture_len = len;
        bus.I_timeout     = tmo;
        bus.I_arm_req     = 1'b1;
        tick();
        chk("arm_wait_lock", {29'd0, bus.O_state}, 32'd1);
        tick();
        chk("arm_armed", {29'd0, bus.O_state}, 32'd2);
        chk("arm_o_arm", {31'd0, bus.O_arm}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n           = 1'b0;
        bus.I_arm_req     = 1'b0;
        bus.I_disarm      = 1'b0;
        bus.I_clk_locked  = 1'b1;
        bus.I_capture_len = 16'd0;
        bus.I_match       = 1'b0;
        bus.I_data_wr     = 1'b0;
        bus.I_fifo_full   = 1'b0;
        bus.I_timeout     = 24'd0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_state", {29'd0, bus.O_state}, 32'd0);
        chk("rst_outs", {26'd0, bus.O_arm, bus.O_capturing, bus.O_done, bus.O_overflow,
                         bus.O_timed_out, 1'b0}, 32'd0);
        chk("rst_count", {16'd0, bus.O_byte_count}, 32'd0);

        // Normal capture of 4 bytes
        arm_to_armed(16'd4, 24'd0);
        bus.I_match = 1'b1;
        tick();
        bus.I_match = 1'b0;
        chk("n_capture", {29'd0, bus.O_state}, 32'd3);
        chk("n_capturing", {31'd0, bus.O_capturing}, 32'd1);
        bus.I_data_wr = 1'b1;
        repeat (3) tick();
        chk("n_count3", {16'd0, bus.O_byte_count}, 32'd3);
        chk("n_no_done3", {31'd0, bus.O_done}, 32'd0);
        tick();
        bus.I_data_wr = 1'b0;
        chk("n_done_state", {29'd0, bus.O_state}, 32'd4);
        chk("n_done", {31'd0, bus.O_done}, 32'd1);
        chk("n_done_arm", {30'd0, bus.O_arm, bus.O_capturing}, 32'd0);
        chk("n_count4", {16'd0, bus.O_byte_count}, 32'd4);
        tick();
        chk("n_idle", {29'd0, bus.O_state}, 32'd0);
        chk("n_done_gone", {31'd0, bus.O_done}, 32'd0);
        chk("n_ovf", {31'd0, bus.O_overflow}, 32'd0);
        tick();
        chk("n_no_rearm_level", {29'd0, bus.O_state}, 32'd0);

        // Overflow on the 6th write of a 10-byte capture
        arm_to_armed(16'd10, 24'd0);
        bus.I_match = 1'b1;
        tick();
        bus.I_match   = 1'b0;
        bus.I_data_wr = 1'b1;
        repeat (5) tick();
        chk("o_count5", {16'd0, bus.O_byte_count}, 32'd5);
        bus.I_fifo_full = 1'b1;
        tick();
        bus.I_data_wr   = 1'b0;
        bus.I_fifo_full = 1'b0;
        chk("o_state", {29'd0, bus.O_state}, 32'd4);
        chk("o_done", {31'd0, bus.O_done}, 32'd1);
        chk("o_ovf", {31'd0, bus.O_overflow}, 32'd1);
        chk("o_count", {16'd0, bus.O_byte_count}, 32'd5);
        tick();
        chk("o_idle", {29'd0, bus.O_state}, 32'd0);
        chk("o_ovf_sticky", {31'd0, bus.O_overflow}, 32'd1);

        // Lock loss while armed, then a normal 2-byte capture
        arm_to_armed(16'd2, 24'd0);
        chk("l_ovf_cleared", {31'd0, bus.O_overflow}, 32'd0);
        bus.I_clk_locked = 1'b0;
        tick();
        chk("l_state", {29'd0, bus.O_state}, 32'd1);
        chk("l_arm", {31'd0, bus.O_arm}, 32'd0);
        bus.I_match = 1'b1;
        repeat (2) tick();
        bus.I_match = 1'b0;
        chk("l_still_wait", {29'd0, bus.O_state}, 32'd1);
        bus.I_clk_locked = 1'b1;
        tick();
        chk("l_rearmed", {29'd0, bus.O_state}, 32'd2);
        chk("l_rearm_arm", {31'd0, bus.O_arm}, 32'd1);
        bus.I_match = 1'b1;
        tick();
        bus.I_match   = 1'b0;
        bus.I_data_wr = 1'b1;
        repeat (2) tick();
        bus.I_data_wr = 1'b0;
        chk("l_done", {31'd0, bus.O_done}, 32'd1);
        chk("l_count", {16'd0, bus.O_byte_count}, 32'd2);
        tick();

        // Disarm together with match while armed
        arm_to_armed(16'd4, 24'd0);
        bus.I_disarm = 1'b1;
        bus.I_match  = 1'b1;
        tick();
        bus.I_disarm = 1'b0;
        bus.I_match  = 1'b0;
        chk("d_state", {29'd0, bus.O_state}, 32'd0);
        chk("d_flags", {29'd0, bus.O_arm, bus.O_capturing, bus.O_done}, 32'd0);
        bus.I_data_wr = 1'b1;
        repeat (2) tick();
        bus.I_data_wr = 1'b0;
        chk("d_stays_idle", {29'd0, bus.O_state}, 32'd0);
        chk("d_flags2", {29'd0, bus.O_arm, bus.O_capturing, bus.O_done}, 32'd0);

        // Asynchronous reset mid-capture; arm level high at release counts as an edge
        arm_to_armed(16'd8, 24'd0);
        bus.I_match = 1'b1;
        tick();
        bus.I_match   = 1'b0;
        bus.I_data_wr = 1'b1;
        repeat (2) tick();
        bus.I_data_wr = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_state", {29'd0, bus.O_state}, 32'd0);
        chk("r_flags", {29'd0, bus.O_arm, bus.O_capturing, bus.O_done}, 32'd0);
        chk("r_count", {16'd0, bus.O_byte_count}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("r_high_edge", {29'd0, bus.O_state}, 32'd1);
        bus.I_disarm = 1'b1;
        tick();
        bus.I_disarm = 1'b0;
        chk("r_disarm", {29'd0, bus.O_state}, 32'd0);

        // Unlimited length: count saturates, FIFO full ends the capture
        arm_to_armed(16'd0, 24'd0);
        bus.I_match = 1'b1;
        tick();
        bus.I_match   = 1'b0;
        bus.I_data_wr = 1'b1;
        repeat (65535) tick();
        chk("s_count_max", {16'd0, bus.O_byte_count}, 32'h0000FFFF);
        chk("s_state_max", {29'd0, bus.O_state}, 32'd3);
        repeat (4465) tick();
        chk("s_count_sat", {16'd0, bus.O_byte_count}, 32'h0000FFFF);
        chk("s_state_sat", {29'd0, bus.O_state}, 32'd3);
        bus.I_fifo_full = 1'b1;
        tick();
        bus.I_data_wr   = 1'b0;
        bus.I_fifo_full = 1'b0;
        chk("s_done", {29'd0, bus.O_state}, 32'd4);
        chk("s_ovf", {31'd0, bus.O_overflow}, 32'd1);
        chk("s_count_end", {16'd0, bus.O_byte_count}, 32'h0000FFFF);
        tick();

`ifdef PW_ARM_TIMEOUT_EN
        arm_to_armed(16'd4, 24'd100);
        repeat (99) tick();
        chk("t_not_yet", {29'd0, bus.O_state}, 32'd2);
        chk("t_not_yet_flag", {31'd0, bus.O_timed_out}, 32'd0);
        tick();
        chk("t_state", {29'd0, bus.O_state}, 32'd4);
        chk("t_done", {31'd0, bus.O_done}, 32'd1);
        chk("t_flag", {31'd0, bus.O_timed_out}, 32'd1);
        chk("t_count", {16'd0, bus.O_byte_count}, 32'd0);
        tick();
        arm_to_armed(16'd4, 24'd0);
        chk("t_flag_cleared", {31'd0, bus.O_timed_out}, 32'd0);
        repeat (10000) tick();
        chk("t0_state", {29'd0, bus.O_state}, 32'd2);
        chk("t0_flag", {31'd0, bus.O_timed_out}, 32'd0);
`else
        arm_to_armed(16'd4, 24'd100);
        repeat (150) tick();
        chk("nt_state", {29'd0, bus.O_state}, 32'd2);
        chk("nt_flag", {31'd0, bus.O_timed_out}, 32'd0);
`endif
        bus.I_disarm = 1'b1;
        tick();
        bus.I_disarm = 1'b0;
        chk("end_idle", {29'd0, bus.O_state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
